// File: rtl/multi_tick_gen_if.sv
// Configuration, enable and tick/status signals of the multi-channel tick generator.
interface multi_tick_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
);
  logic [NUM_CH-1:0] en;
  logic              load;
  logic [3:0]        load_ch;
  logic [CNT_W-1:0]  load_div;
  logic              load_oneshot;
  logic [NUM_CH-1:0] tick_out;
  logic [NUM_CH-1:0] sq_out;
  logic [NUM_CH-1:0] busy;
  logic              cfg_err;

  modport master (
    output en, load, load_ch, load_div, load_oneshot,
    input  tick_out, sq_out, busy, cfg_err
  );

  modport slave (
    input  en, load, load_ch, load_div, load_oneshot,
    output tick_out, sq_out, busy, cfg_err
  );
endinterface

// File: rtl/multi_tick_gen.sv
// Programmable per-channel clock divider: tick pulse and square wave of period D, optional one-shot.
// All outputs registered (1 cycle after the causing edge); no backpressure, loads are fire-and-forget.
module multi_tick_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 10_000_000
) (
  input logic             clk,
  input logic             rst,
  multi_tick_gen_if.slave bus
);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic              cfg_err_q, cfg_err_d;
  logic              load_ok;
  logic              wrap;
  logic [CNT_W-1:0]  cnt_nxt;

  always_comb begin
    load_ok   = bus.load && ({1'b0, bus.load_ch} < 5'(NUM_CH))
                && (bus.load_div >= CNT_W'(2));
    cfg_err_d = bus.load && !load_ok;
    mode_d    = mode_q;
    done_d    = done_q;
    tick_d    = '0;
    sq_d      = '0;
    busy_d    = '0;
    wrap      = 1'b0;
    cnt_nxt   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      div_d[i] = div_q[i];
      if (load_ok && (bus.load_ch == 4'(i))) begin
        // A load overrides both a coincident wrap and a falling enable.
        div_d[i]  = bus.load_div;
        mode_d[i] = bus.load_oneshot;
        done_d[i] = 1'b0;
      end else if (!bus.en[i]) begin
        done_d[i] = 1'b0;
      end else if (!done_q[i]) begin
        wrap      = (cnt_q[i] == (div_q[i] - CNT_W'(1)));
        cnt_nxt   = wrap ? '0 : (cnt_q[i] + CNT_W'(1));
        cnt_d[i]  = cnt_nxt;
        tick_d[i] = wrap;
        done_d[i] = wrap && mode_q[i];
        sq_d[i]   = !(wrap && mode_q[i]) && (cnt_nxt >= (div_q[i] >> 1));
      end
      busy_d[i] = bus.en[i] && !done_d[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= CNT_W'(DEFAULT_DIV);
      end
      mode_q    <= '0;
      done_q    <= '0;
      tick_q    <= '0;
      sq_q      <= '0;
      busy_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      mode_q    <= mode_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.tick_out = tick_q;
  assign bus.sq_out   = sq_q;
  assign bus.busy     = busy_q;
  assign bus.cfg_err  = cfg_err_q;

endmodule
